pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: IFID_rn, IFID_rm, IFID_rt  in  5 each  source register fields of the instruction in ID.
REQ-004 SHALL have ports: IFID_usesRm, IFID_isCBZ, IFID_halt  in  1 each  ID instruction reads Rm / is CBZ (tests Rt) / is HALT.
REQ-005 SHALL have ports: IDEX_rd  in  5, IDEX_memRead  in  1, IDEX_regWrite  in  1  EX-stage destination, load flag, writeback flag.
REQ-006 SHALL have ports: EXMEM_rd  in  5, EXMEM_memRead  in  1  MEM-stage destination and load flag.
REQ-007 SHALL have ports: takeBranch  in  1  ID-stage branch decision; dmem_busy  in  1  data memory has not completed the MEM-stage access.
REQ-008 SHALL have ports: PCWrite, IFID_write, IFID_flush, IDEX_bubble, pipe_freeze, branch_en, halted  out  1 each.
REQ-009 SHALL have ports: stall_cycles, flush_count  out  16 each  saturating performance counters.

Function
REQ-010 SHALL implement states RUN, HAZ, DRAIN, HALTED, with a 2-bit remaining-count register rem.
REQ-011 Register X31 SHALL never match as a dependence (XZR).
REQ-012 In RUN, hazard length L SHALL be: 2 if IFID_isCBZ and IDEX_memRead and IDEX_rd==IFID_rt; else 1 if IFID_isCBZ and ((IDEX_regWrite and IDEX_rd==IFID_rt) or (EXMEM_memRead and EXMEM_rd==IFID_rt)); else 1 if IDEX_memRead and (IDEX_rd==IFID_rn or (IFID_usesRm and IDEX_rd==IFID_rm)); else 0.
REQ-013 Stall outputs: PCWrite=0, IFID_write=0, IDEX_bubble=1, branch_en=0, IFID_flush=0.
REQ-014 In RUN with L>0: SHALL drive stall outputs; next state HAZ with rem=L-1 if L==2, else remain RUN.
REQ-015 In HAZ: SHALL drive stall outputs; L is not re-evaluated; rem decrements; when rem==0 at the edge, next state RUN.
REQ-016 In RUN with L==0 and takeBranch=1: branch_en=1, PCWrite=1, IFID_flush=1 (fetched instruction squashed), IDEX_bubble=0.
REQ-017 In RUN with L==0, takeBranch=0, IFID_halt=0: PCWrite=1, IFID_write=1, all other control outputs 0.
REQ-018 In RUN with L==0 and IFID_halt=1: PCWrite=0, IFID_flush=1, next state DRAIN with rem=3; HALT itself proceeds to EX.
REQ-019 In DRAIN: PCWrite=0, IFID_write=0, IDEX_bubble=1; rem decrements; at rem==0 next state HALTED.
REQ-020 In HALTED: PCWrite=0, IFID_write=0, IDEX_bubble=1, halted=1; exit only via reset.
REQ-021 dmem_busy=1 SHALL override all states: pipe_freeze=1, PCWrite=0, IFID_write=0, IDEX_bubble=0, IFID_flush=0, branch_en=0; state and rem held.
REQ-022 Priority SHALL be dmem_busy > HALTED/DRAIN > HAZ > RUN hazard > takeBranch > IFID_halt.
REQ-023 stall_cycles SHALL increment on each edge where stall outputs or pipe_freeze were driven (HAZ, RUN with L>0, or dmem_busy), saturating at 0xFFFF.
REQ-024 flush_count SHALL increment on each edge where IFID_flush=1, saturating at 0xFFFF.
REQ-025 All outputs SHALL be combinational from state, rem and inputs; no output SHALL depend on a future-cycle input.

Reset
REQ-026 On reset low, SHALL asynchronously set state=RUN, rem=0, stall_cycles=0, flush_count=0; outputs then follow REQ-017 for current inputs.
REQ-027 Reset asserted mid-HAZ, DRAIN, HALTED or freeze SHALL abandon that operation immediately; first edge after release evaluates from RUN.

Verification
REQ-028 LDUR X2 in EX, ADD reads X2 in ID -> 1 cycle PCWrite=0/IDEX_bubble=1, stall_cycles=1, then RUN.
REQ-029 LDUR X3 in EX, CBZ X3 in ID with takeBranch=1 -> 2 stall cycles (RUN then HAZ), branch_en=0 both; third cycle branch_en=1, IFID_flush=1, flush_count=1.
REQ-030 IDEX_rd=31 with IDEX_memRead=1, IFID_rn=31 -> no stall, PCWrite=1.
REQ-031 dmem_busy=1 for 3 cycles during HAZ rem=1 -> pipe_freeze=1 three cycles, rem stays 1, stall_cycles +3, then one HAZ cycle, then RUN.
REQ-032 IFID_halt=1 -> 1 flush cycle, 3 DRAIN cycles, halted=1 persistent; reset low -> halted=0, counters=0.
REQ-033 Force 70000 stall cycles -> stall_cycles holds 0xFFFF, no wrap.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-to-hazard-controller signal bundle: stage fields in, pipeline steering and counters out.
interface pipe_hazard_ctrl_if;
  logic [4:0]  IFID_rn;
  logic [4:0]  IFID_rm;
  logic [4:0]  IFID_rt;
  logic        IFID_usesRm;
  logic        IFID_isCBZ;
  logic        IFID_halt;
  logic [4:0]  IDEX_rd;
  logic        IDEX_memRead;
  logic        IDEX_regWrite;
  logic [4:0]  EXMEM_rd;
  logic        EXMEM_memRead;
  logic        takeBranch;
  logic        dmem_busy;
  logic        PCWrite;
  logic        IFID_write;
  logic        IFID_flush;
  logic        IDEX_bubble;
  logic        pipe_freeze;
  logic        branch_en;
  logic        halted;
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;

  // The pipeline datapath drives stage fields and consumes the steering signals.
  modport master (
    output IFID_rn, IFID_rm, IFID_rt, IFID_usesRm, IFID_isCBZ, IFID_halt,
    output IDEX_rd, IDEX_memRead, IDEX_regWrite, EXMEM_rd, EXMEM_memRead,
    output takeBranch, dmem_busy,
    input  PCWrite, IFID_write, IFID_flush, IDEX_bubble, pipe_freeze, branch_en, halted,
    input  stall_cycles, flush_count
  );

  modport slave (
    input  IFID_rn, IFID_rm, IFID_rt, IFID_usesRm, IFID_isCBZ, IFID_halt,
    input  IDEX_rd, IDEX_memRead, IDEX_regWrite, EXMEM_rd, EXMEM_memRead,
    input  takeBranch, dmem_busy,
    output PCWrite, IFID_write, IFID_flush, IDEX_bubble, pipe_freeze, branch_en, halted,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use / CBZ stalls, branch flush, HALT drain,
// data-memory freeze, and saturating stall/flush performance counters.
module pipe_hazard_ctrl (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, HAZ, DRAIN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rem_q, rem_d;
  logic [1:0]  haz_len;
  logic        stall_evt;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, freeze, br_en;
  logic [15:0] stall_cycles_q, flush_count_q;

  // X31 reads as zero, so it never carries a dependence.
  function automatic logic dep(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd31);
  endfunction

  always_comb begin
    haz_len = 2'd0;
    if (bus.IFID_isCBZ && bus.IDEX_memRead && dep(bus.IDEX_rd, bus.IFID_rt))
      haz_len = 2'd2;
    else if (bus.IFID_isCBZ &&
             ((bus.IDEX_regWrite && dep(bus.IDEX_rd, bus.IFID_rt)) ||
              (bus.EXMEM_memRead && dep(bus.EXMEM_rd, bus.IFID_rt))))
      haz_len = 2'd1;
    else if (bus.IDEX_memRead &&
             (dep(bus.IDEX_rd, bus.IFID_rn) ||
              (bus.IFID_usesRm && dep(bus.IDEX_rd, bus.IFID_rm))))
      haz_len = 2'd1;
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    br_en       = 1'b0;
    stall_evt   = 1'b0;

    if (bus.dmem_busy) begin
      freeze    = 1'b1;
      stall_evt = 1'b1;
    end else begin
      unique case (state_q)
        HALTED: idex_bubble = 1'b1;
        DRAIN: begin
          idex_bubble = 1'b1;
          if (rem_q <= 2'd1) begin
            rem_d   = 2'd0;
            state_d = HALTED;
          end else begin
            rem_d = rem_q - 2'd1;
          end
        end
        HAZ: begin
          idex_bubble = 1'b1;
          stall_evt   = 1'b1;
          if (rem_q <= 2'd1) begin
            rem_d   = 2'd0;
            state_d = RUN;
          end else begin
            rem_d = rem_q - 2'd1;
          end
        end
        default: begin
          if (haz_len != 2'd0) begin
            idex_bubble = 1'b1;
            stall_evt   = 1'b1;
            if (haz_len == 2'd2) begin
              state_d = HAZ;
              rem_d   = 2'd1;
            end
          end else if (bus.takeBranch) begin
            // IF/ID still advances; the flush turns the fetched instruction into a NOP.
            br_en      = 1'b1;
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b1;
          end else if (bus.IFID_halt) begin
            ifid_flush = 1'b1;
            state_d    = DRAIN;
            rem_d      = 2'd3;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= RUN;
      rem_q          <= 2'd0;
      stall_cycles_q <= 16'd0;
      flush_count_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (stall_evt && (stall_cycles_q != 16'hFFFF))
        stall_cycles_q <= stall_cycles_q + 16'd1;
      if (ifid_flush && (flush_count_q != 16'hFFFF))
        flush_count_q <= flush_count_q + 16'd1;
    end
  end

  assign bus.PCWrite      = pc_write;
  assign bus.IFID_write   = ifid_write;
  assign bus.IFID_flush   = ifid_flush;
  assign bus.IDEX_bubble  = idex_bubble;
  assign bus.pipe_freeze  = freeze;
  assign bus.branch_en    = br_en;
  assign bus.halted       = (state_q == HALTED);
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle-level behavioural model is compared every
// cycle, and hand-computed literal expectations pin specific scenarios.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owed;      // extra stall cycles still owed after the current one
  int m_drain;     // drain cycles remaining before halting
  bit m_halted;
  int m_stall;
  int m_flush;

  function automatic bit m_dep(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != 5'd31);
  endfunction

  function automatic int m_len();
    if (bus.IFID_isCBZ && bus.IDEX_memRead && m_dep(bus.IDEX_rd, bus.IFID_rt)) return 2;
    if (bus.IFID_isCBZ && ((bus.IDEX_regWrite && m_dep(bus.IDEX_rd, bus.IFID_rt)) ||
                           (bus.EXMEM_memRead && m_dep(bus.EXMEM_rd, bus.IFID_rt)))) return 1;
    if (bus.IDEX_memRead && (m_dep(bus.IDEX_rd, bus.IFID_rn) ||
                             (bus.IFID_usesRm && m_dep(bus.IDEX_rd, bus.IFID_rm)))) return 1;
    return 0;
  endfunction

  // {PCWrite, IFID_write, IFID_flush, IDEX_bubble, pipe_freeze, branch_en, halted}
  function automatic logic [6:0] m_ctrl();
    logic [6:0] v;
    if (bus.dmem_busy)               v = 7'b0000100;
    else if (m_halted)               v = 7'b0001000;
    else if (m_drain > 0)            v = 7'b0001000;
    else if (m_owed > 0)             v = 7'b0001000;
    else if (m_len() > 0)            v = 7'b0001000;
    else if (bus.takeBranch)         v = 7'b1110010;
    else if (bus.IFID_halt)          v = 7'b0010000;
    else                             v = 7'b1100000;
    v[0] = m_halted;
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_owed   <= 0;
      m_drain  <= 0;
      m_halted <= 1'b0;
      m_stall  <= 0;
      m_flush  <= 0;
    end else if (bus.dmem_busy) begin
      m_stall <= (m_stall < 65535) ? m_stall + 1 : 65535;
    end else if (m_halted) begin
      m_halted <= 1'b1;
    end else if (m_drain > 0) begin
      m_drain <= m_drain - 1;
      if (m_drain == 1) m_halted <= 1'b1;
    end else if (m_owed > 0) begin
      m_owed  <= m_owed - 1;
      m_stall <= (m_stall < 65535) ? m_stall + 1 : 65535;
    end else if (m_len() > 0) begin
      m_owed  <= m_len() - 1;
      m_stall <= (m_stall < 65535) ? m_stall + 1 : 65535;
    end else if (bus.takeBranch) begin
      m_flush <= (m_flush < 65535) ? m_flush + 1 : 65535;
    end else if (bus.IFID_halt) begin
      m_flush <= (m_flush < 65535) ? m_flush + 1 : 65535;
      m_drain <= 3;
    end
  end

  // Compare process: outputs are sampled mid-cycle against the model.
  always @(negedge clk) begin
    logic [15:0] es, ef;
    es = 16'(m_stall);
    ef = 16'(m_flush);
    check("model_cmp",
          {25'd0, bus.PCWrite, bus.IFID_write, bus.IFID_flush, bus.IDEX_bubble,
           bus.pipe_freeze, bus.branch_en, bus.halted, bus.stall_cycles, bus.flush_count},
          {25'd0, m_ctrl(), es, ef});
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.IFID_rn = 5'd0;  bus.IFID_rm = 5'd0;  bus.IFID_rt = 5'd0;
    bus.IFID_usesRm = 1'b0; bus.IFID_isCBZ = 1'b0; bus.IFID_halt = 1'b0;
    bus.IDEX_rd = 5'd0;  bus.IDEX_memRead = 1'b0; bus.IDEX_regWrite = 1'b0;
    bus.EXMEM_rd = 5'd0; bus.EXMEM_memRead = 1'b0;
    bus.takeBranch = 1'b0; bus.dmem_busy = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cbz_after_load(input logic [4:0] r);
    idle();
    bus.IDEX_rd = r; bus.IDEX_memRead = 1'b1; bus.IDEX_regWrite = 1'b1;
    bus.IFID_isCBZ = 1'b1; bus.IFID_rt = r; bus.takeBranch = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle();
    #22;
    check("reset_pcwrite", 64'(bus.PCWrite), 64'd1);
    check("reset_ifid_write", 64'(bus.IFID_write), 64'd1);
    check("reset_counters", {32'd0, bus.stall_cycles, bus.flush_count}, 64'd0);
    reset = 1'b1;
    tick();

    // Load-use: LDUR X2 in EX, ADD reads X2.
    idle();
    bus.IDEX_rd = 5'd2; bus.IDEX_memRead = 1'b1; bus.IDEX_regWrite = 1'b1; bus.IFID_rn = 5'd2;
    #2;
    check("ldu_pcwrite", 64'(bus.PCWrite), 64'd0);
    check("ldu_bubble", 64'(bus.IDEX_bubble), 64'd1);
    tick();
    idle();
    bus.EXMEM_rd = 5'd2; bus.EXMEM_memRead = 1'b1; bus.IFID_rn = 5'd2;
    #2;
    check("ldu_stall_cnt", 64'(bus.stall_cycles), 64'd1);
    check("ldu_resume", 64'(bus.PCWrite), 64'd1);
    tick();

    // CBZ right behind a load of its test register: two stalls then the branch.
    cbz_after_load(5'd3);
    #2;
    check("cbz_c1_branch_en", 64'(bus.branch_en), 64'd0);
    tick();
    idle();
    bus.IFID_isCBZ = 1'b1; bus.IFID_rt = 5'd3; bus.takeBranch = 1'b1;
    bus.EXMEM_rd = 5'd3; bus.EXMEM_memRead = 1'b1;
    #2;
    check("cbz_c2_branch_en", 64'(bus.branch_en), 64'd0);
    check("cbz_c2_bubble", 64'(bus.IDEX_bubble), 64'd1);
    tick();
    idle();
    bus.IFID_isCBZ = 1'b1; bus.IFID_rt = 5'd3; bus.takeBranch = 1'b1;
    #2;
    check("cbz_c3_branch", {62'd0, bus.branch_en, bus.IFID_flush}, 64'd3);
    tick();
    idle();
    check("cbz_flush_cnt", 64'(bus.flush_count), 64'd1);
    check("cbz_stall_cnt", 64'(bus.stall_cycles), 64'd3);

    // XZR never creates a dependence.
    bus.IDEX_rd = 5'd31; bus.IDEX_memRead = 1'b1; bus.IFID_rn = 5'd31;
    bus.IFID_usesRm = 1'b1; bus.IFID_rm = 5'd31;
    #2;
    check("xzr_pcwrite", 64'(bus.PCWrite), 64'd1);
    tick();

    // Single-stall variants and non-stalls (model-checked each cycle).
    idle(); bus.IFID_isCBZ = 1'b1; bus.IFID_rt = 5'd7; bus.IDEX_rd = 5'd7; bus.IDEX_regWrite = 1'b1;
    tick();
    idle(); bus.IFID_isCBZ = 1'b1; bus.IFID_rt = 5'd9; bus.EXMEM_rd = 5'd9; bus.EXMEM_memRead = 1'b1;
    tick();
    idle(); bus.IDEX_rd = 5'd4; bus.IDEX_memRead = 1'b1; bus.IFID_rn = 5'd1;
    bus.IFID_rm = 5'd4; bus.IFID_usesRm = 1'b1;
    tick();
    idle(); bus.IDEX_rd = 5'd4; bus.IDEX_memRead = 1'b1; bus.IFID_rn = 5'd1; bus.IFID_rm = 5'd4;
    #2;
    check("rm_unused_pcwrite", 64'(bus.PCWrite), 64'd1);
    tick();
    idle(); bus.IFID_isCBZ = 1'b1; bus.IFID_rt = 5'd31; bus.IDEX_rd = 5'd31; bus.IDEX_memRead = 1'b1;
    tick();
    idle();
    check("variants_stall_cnt", 64'(bus.stall_cycles), 64'd6);

    // Memory busy for three cycles in the middle of a CBZ hazard.
    cbz_after_load(5'd5);
    tick();
    idle();
    bus.dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("busy_freeze", {62'd0, bus.pipe_freeze, bus.PCWrite}, 64'd2);
      tick();
    end
    bus.dmem_busy = 1'b0;
    #2;
    check("busy_haz_resume", {62'd0, bus.pipe_freeze, bus.IDEX_bubble}, 64'd1);
    tick();
    #2;
    check("busy_back_to_run", 64'(bus.PCWrite), 64'd1);
    check("busy_stall_cnt", 64'(bus.stall_cycles), 64'd11);

    // Freeze outranks a pending load-use stall.
    bus.IDEX_rd = 5'd6; bus.IDEX_memRead = 1'b1; bus.IFID_rn = 5'd6; bus.dmem_busy = 1'b1;
    #1;
    check("busy_over_hazard", {60'd0, bus.pipe_freeze, bus.PCWrite, bus.IDEX_bubble, bus.IFID_write}, 64'd8);
    tick();
    idle();
    tick();

    // Reset in the middle of a hazard abandons it.
    cbz_after_load(5'd8);
    tick();
    idle();
    #1;
    reset = 1'b0;
    #1;
    check("rst_mid_haz", {62'd0, bus.PCWrite, bus.IDEX_bubble}, 64'd2);
    check("rst_mid_haz_cnt", 64'(bus.stall_cycles), 64'd0);
    #1;
    reset = 1'b1;
    tick();

    // Branch outranks HALT.
    bus.takeBranch = 1'b1; bus.IFID_halt = 1'b1;
    #2;
    check("branch_over_halt", {62'd0, bus.branch_en, bus.IFID_flush}, 64'd3);
    tick();

    // HALT: one flush cycle, three drain cycles, then halted until reset.
    idle();
    bus.IFID_halt = 1'b1;
    #2;
    check("halt_flush", {61'd0, bus.IFID_flush, bus.PCWrite, bus.IDEX_bubble}, 64'd4);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #2;
      check("drain_cycle", {61'd0, bus.IDEX_bubble, bus.halted, bus.PCWrite}, 64'd4);
      tick();
    end
    bus.takeBranch = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("halted_hold", {61'd0, bus.halted, bus.PCWrite, bus.branch_en}, 64'd4);
      tick();
    end
    bus.dmem_busy = 1'b1;
    tick();
    idle();
    #2;
    check("halt_flush_cnt", 64'(bus.flush_count), 64'd2);
    reset = 1'b0;
    #1;
    check("halt_reset", {31'd0, bus.halted, bus.stall_cycles, bus.flush_count}, 64'd0);
    reset = 1'b1;
    tick();

    // Saturation: 70000 consecutive load-use stalls.
    bus.IDEX_rd = 5'd2; bus.IDEX_memRead = 1'b1; bus.IFID_rn = 5'd2;
    for (int i = 0; i < 70000; i++) tick();
    idle();
    check("stall_saturate", 64'(bus.stall_cycles), 64'hFFFF);
    tick();
    check("stall_saturate_hold", 64'(bus.stall_cycles), 64'hFFFF);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
